// File: rtl/spi_pkg.sv
// Shared SPI definitions: op encodings, frame geometry and master FSM states.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Command as it goes on the wire: op bits lead, payload follows, MSB first.
    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } spi_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP,
        RECV,
        GUARD
    } spi_mst_state_e;

endpackage

// File: rtl/spi_master_shreg.sv
// Parameterised shift register: parallel load, shifts toward the MSB, new bit enters at the LSB.
module spi_master_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    // Load wins over shift so a fresh frame is never corrupted by a stale shift strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= {q[W-2:0], sin};
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit {op,data} frames on MOSI under SS_n, captures
// the 8-bit MISO reply for read-data and returns it as a one-cycle response.
module spi_master
    import spi_pkg::*;
#(
    parameter int READ_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO
);

    spi_mst_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              tx_load, tx_shift, rx_shift;
    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;
    spi_cmd_t           cmd_in;

    assign cmd_in = '{op: cmd_op, data: cmd_data};

    spi_master_shreg #(.W(FRAME_W)) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .load_val (cmd_in),
        .shift    (tx_shift),
        .sin      (1'b0),
        .q        (tx_q)
    );

    spi_master_shreg #(.W(DATA_W)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ('0),
        .shift    (rx_shift),
        .sin      (MISO),
        .q        (rx_q)
    );

    // Only the TX MSB reaches MOSI; the RX MSB is superseded by the byte assembled into rsp_data.
    logic unused_bits;
    assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

    // State, counter and all outputs are registered; SS_n goes high asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_WR_ADDR;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next state plus next output values, so each output reflects the state it is registered with.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        ss_d       = 1'b1;
        mosi_d     = 1'b0;
        ready_d    = 1'b0;
        rsp_vld_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = LEAD;
                    op_d    = cmd_op;
                    tx_load = 1'b1;
                    ss_d    = 1'b0;
                    mosi_d  = cmd_op[1];   // frame bit 9 is shown during the lead cycle too
                end else begin
                    ready_d = 1'b1;
                end
            end
            LEAD: begin
                state_d  = SHIFT;
                cnt_d    = CNT_W'(FRAME_W - 1);
                ss_d     = 1'b0;
                mosi_d   = tx_q[FRAME_W-1];
                tx_shift = 1'b1;
            end
            SHIFT: begin
                ss_d = 1'b0;
                if (cnt_q == '0) begin
                    if (op_q == OP_RD_DATA) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(READ_GAP - 1);
                    end else begin
                        state_d = GUARD;
                        ss_d    = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mosi_d   = tx_q[FRAME_W-1];
                    tx_shift = 1'b1;
                end
            end
            GAP: begin
                ss_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = RECV;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECV: begin
                ss_d     = 1'b0;
                rx_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = GUARD;
                    ss_d       = 1'b1;
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = {rx_q[DATA_W-2:0], MISO};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GUARD: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_data_q;
    assign MOSI      = mosi_q;
    assign SS_n      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a timeline model checked every cycle, plus directed literals.
module tb_spi_master;

    localparam int RG = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, MOSI, SS_n;
    logic [7:0] rsp_data;
    logic       MISO = 1'b0;

    always #5 clk = ~clk;

    spi_master #(.READ_GAP(RG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timeline model: k counts cycles since the accept edge (cycle T+1 has k=1).
    logic       busy = 1'b0, armed = 1'b0, mrd = 1'b0;
    int         k = 0;
    int         accepts = 0;
    logic [9:0] mf = 10'h0;
    logic [7:0] mbyte = 8'h0, exp_rdata = 8'h0, next_reply = 8'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            armed     <= 1'b0;
            k         <= 0;
            exp_rdata <= 8'h00;
        end else begin
            armed <= 1'b1;
            if (!busy) begin
                if (cmd_valid && armed) begin
                    busy    <= 1'b1;
                    k       <= 1;
                    mf      <= {cmd_op, cmd_data};
                    mrd     <= (cmd_op == 2'b11);
                    mbyte   <= next_reply;
                    accepts <= accepts + 1;
                end
            end else begin
                k <= k + 1;
                if (mrd && (k + 1 == 20 + RG)) exp_rdata <= mbyte;
                if (k + 1 == (mrd ? 21 + RG : 13)) busy <= 1'b0;
            end
        end
    end

    function automatic logic e_ss();
        int len;
        len = mrd ? 19 + RG : 11;
        return !(busy && k >= 1 && k <= len);
    endfunction

    function automatic logic e_mosi();
        if (!busy) return 1'b0;
        if (k == 1) return mf[9];
        if (k >= 2 && k <= 11) return mf[11 - k];
        return 1'b0;
    endfunction

    // Slave reply: MSB first across the receive window, noise everywhere else.
    always @(negedge clk) begin
        if (busy && mrd && k >= 12 + RG && k <= 19 + RG)
            MISO <= mbyte[7 - (k - 12 - RG)];
        else
            MISO <= 1'($urandom_range(0, 1));
    end

    always @(posedge clk) cyc <= cyc + 1;

    // History (indexed by cycle number) and the per-cycle model comparison.
    logic       ss_hist    [0:4095];
    logic       mosi_hist  [0:4095];
    logic       rsp_hist   [0:4095];
    logic       ready_hist [0:4095];
    logic [7:0] rdata_hist [0:4095];
    int         falls = 0;
    logic       ss_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (cyc < 4095) begin
            ss_hist[cyc+1]    <= SS_n;
            mosi_hist[cyc+1]  <= MOSI;
            rsp_hist[cyc+1]   <= rsp_valid;
            ready_hist[cyc+1] <= cmd_ready;
            rdata_hist[cyc+1] <= rsp_data;
        end
        if (ss_prev && !SS_n) falls <= falls + 1;
        ss_prev <= SS_n;
        chk("ss_n",      SS_n,      e_ss());
        chk("mosi",      MOSI,      e_mosi());
        chk("cmd_ready", cmd_ready, armed && !busy);
        chk("rsp_valid", rsp_valid, busy && mrd && k == 20 + RG);
        chk("rsp_data",  rsp_data,  exp_rdata);
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, output int t);
        bit ok;
        ok = 0;
        t  = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                t  = cyc;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        chk("idle_timeout", ok, 1);
    endtask

    function automatic int pulses(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (rsp_hist[i] === 1'b1) n++;
        return n;
    endfunction

    // Host-side view of the slave RAM, used to predict read-data replies.
    logic [7:0] ram [0:255];
    logic [7:0] waddr = 8'h0, raddr = 8'h0;

    task automatic send_ram(input logic [1:0] op, input logic [7:0] d, output int t);
        case (op)
            2'b00: waddr = d;
            2'b01: ram[waddr] = d;
            2'b10: raddr = d;
            default: next_reply = ram[raddr];
        endcase
        send(op, d, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int f0, a0;
        logic [9:0] wa_bits;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // Power-on reset, then release
        repeat (3) @(negedge clk);
        chk("por_ss", SS_n, 1);
        chk("por_ready", cmd_ready, 0);
        chk("por_rdata", rsp_data, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_por", cmd_ready, 1);

        // Reset in the middle of SHIFT for frame 10'h2A5
        send(2'b10, 8'hA5, t);
        repeat (4) @(posedge clk);
        #3;
        chk("mid_shift_ss_low", SS_n, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_ss_async", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Write-address 0x12: literal waveform
        wa_bits = 10'b00_0001_0010;
        send_ram(2'b00, 8'h12, t);
        repeat (13) @(posedge clk);
        #2;
        for (int i = 1; i <= 11; i++) chk("wa_ss_low", ss_hist[t+i], 0);
        chk("wa_ss_high", ss_hist[t+12], 1);
        chk("wa_lead_mosi", mosi_hist[t+1], 0);
        for (int i = 2; i <= 11; i++) chk("wa_mosi", mosi_hist[t+i], wa_bits[11-i]);
        chk("wa_not_ready", ready_hist[t+12], 0);
        chk("wa_ready", ready_hist[t+13], 1);

        // RAM round trip: write 0xA5 at 0x12, then read it back
        send_ram(2'b01, 8'hA5, t);
        wait_idle();
        send_ram(2'b10, 8'h12, t);
        wait_idle();
        send_ram(2'b11, 8'h00, t);
        repeat (24) @(posedge clk);
        #2;
        chk("rt_pulse", rsp_hist[t+22], 1);
        chk("rt_data", rdata_hist[t+22], 8'hA5);
        chk("rt_one_pulse", pulses(t + 1, t + 24), 1);
        chk("rt_ready", ready_hist[t+23], 1);

        // Direct MISO reply 0xC3, data must hold after the pulse
        next_reply = 8'hC3;
        send(2'b11, 8'h5F, t);
        repeat (26) @(posedge clk);
        #2;
        chk("c3_pulse", rsp_hist[t+22], 1);
        chk("c3_data", rdata_hist[t+22], 8'hC3);
        chk("c3_pulse_end", rsp_hist[t+23], 0);
        chk("c3_hold", rdata_hist[t+25], 8'hC3);

        // cmd_valid held high with changing data: one accept per frame
        wait_idle();
        f0 = falls;
        a0 = accepts;
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 2));
        cmd_data  = 8'($urandom);
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            cmd_op   = 2'($urandom_range(0, 2));
            cmd_data = 8'($urandom);
        end
        cmd_valid = 1'b0;
        wait_idle();
        chk("busy_falls", falls - f0, 3);
        chk("busy_accepts", accepts - a0, 3);

        // Reset during RECV of a read-data, then a clean read-data
        next_reply = 8'h3C;
        send(2'b11, 8'h00, t);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("recv_rst_ss", SS_n, 1);
        chk("recv_rst_rdata", rsp_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        chk("recv_rst_no_pulse", pulses(t + 1, t + 30), 0);
        next_reply = 8'h5A;
        send(2'b11, 8'hFF, t);
        repeat (24) @(posedge clk);
        #2;
        chk("after_rst_pulse", rsp_hist[t+22], 1);
        chk("after_rst_data", rdata_hist[t+22], 8'h5A);
        chk("after_rst_one", pulses(t + 1, t + 24), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
